// File: rtl/usb_rx_nrzi_unstuff.sv
// usb_rx_nrzi_unstuff
//   Full-speed USB receive front end. Takes the synchronized D+/D- pair,
//   evaluates it once per bit-centre strobe, and performs NRZI decoding,
//   SYNC detection, bit-unstuffing and EOP detection. Delivers one decoded
//   data bit per rx_bit_valid pulse plus packet framing pulses.
//
// Parameters
//   SYNC_MIN_ZEROS : decoded 0s required before the terminating 1 of SYNC (1..6)
//   EOP_MAX_SE0    : longest SE0 run accepted as an EOP; one more is a line error
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   sample_en    in   bit-centre strobe; dp/dm are only looked at when high
//   dp, dm       in   synchronized D+ / D-
//   rx_bit       out  decoded, unstuffed bit (qualified by rx_bit_valid)
//   rx_bit_valid out  one-cycle pulse per delivered data bit
//   rx_active    out  high from the sop cycle through the eop/error cycle
//   sop          out  pulse when SYNC completes
//   eop          out  pulse on a valid EOP
//   stuff_err    out  pulse on a bit-stuff violation
//   line_err     out  pulse on SE1, bad EOP or over-long SE0
//
// Every output is a flop and changes only in the cycle after a sample_en
// cycle, except that pulses self-clear and rx_active falls together with
// the terminating pulse.

module usb_rx_nrzi_unstuff #(
  parameter int SYNC_MIN_ZEROS = 3,
  parameter int EOP_MAX_SE0    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic dp,
  input  logic dm,
  output logic rx_bit,
  output logic rx_bit_valid,
  output logic rx_active,
  output logic sop,
  output logic eop,
  output logic stuff_err,
  output logic line_err
);

  localparam int SE0_W = $clog2(EOP_MAX_SE0 + 1) + 1;
  localparam logic [2:0]       MIN_ZEROS = 3'(SYNC_MIN_ZEROS);
  localparam logic [SE0_W-1:0] SE0_LIM   = SE0_W'(EOP_MAX_SE0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC     = 2'd1,
    DATA     = 2'd2,
    EOP_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic             prev_level;  // last J/K level seen, stored as its dp value
  logic             armed;       // a J has been seen since the last return to IDLE
  logic [2:0]       zero_cnt;
  logic [2:0]       ones_cnt;
  logic [SE0_W-1:0] se0_cnt;

  // Line state decode
  logic is_j, is_k, is_se0, is_se1;
  logic dec;

  always_comb begin
    is_j   = dp  & ~dm;
    is_k   = ~dp & dm;
    is_se0 = ~dp & ~dm;
    is_se1 = dp  & dm;
    // NRZI: no transition is a 1. Only meaningful on J/K samples.
    dec    = (dp == prev_level);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev_level   <= 1'b1;
      armed        <= 1'b0;
      zero_cnt     <= '0;
      ones_cnt     <= '0;
      se0_cnt      <= '0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      rx_active    <= 1'b0;
      sop          <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      line_err     <= 1'b0;
    end else begin
      rx_bit_valid <= 1'b0;
      sop          <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      line_err     <= 1'b0;

      // rx_active is held through the cycle that carries the terminating
      // pulse and falls as that pulse clears.
      if (eop || stuff_err || line_err)
        rx_active <= 1'b0;

      if (sample_en) begin
        unique case (state)
          IDLE: begin
            if (is_j) begin
              prev_level <= 1'b1;
              armed      <= 1'b1;
            end else if (is_k) begin
              // J->K transition after a fresh J starts a SYNC; that K is
              // already the first decoded 0.
              if (armed && prev_level) begin
                state    <= SYNC;
                zero_cnt <= 3'd1;
              end
              prev_level <= 1'b0;
            end
          end

          SYNC: begin
            if (is_j || is_k) begin
              prev_level <= dp;
              if (!dec) begin
                if (zero_cnt != 3'd7)
                  zero_cnt <= zero_cnt + 3'd1;
              end else if (zero_cnt >= MIN_ZEROS) begin
                // The SYNC's closing 1 starts the ones run for unstuffing.
                state     <= DATA;
                sop       <= 1'b1;
                rx_active <= 1'b1;
                ones_cnt  <= 3'd1;
              end else begin
                state      <= IDLE;
                prev_level <= 1'b1;
                armed      <= 1'b0;
                zero_cnt   <= '0;
              end
            end else begin
              state      <= IDLE;
              prev_level <= 1'b1;
              armed      <= 1'b0;
              zero_cnt   <= '0;
            end
          end

          DATA: begin
            if (is_se0) begin
              state   <= EOP_WAIT;
              se0_cnt <= SE0_W'(1);
            end else if (is_se1) begin
              line_err   <= 1'b1;
              state      <= IDLE;
              prev_level <= 1'b1;
              armed      <= 1'b0;
              ones_cnt   <= '0;
            end else begin
              prev_level <= dp;
              if (ones_cnt == 3'd6) begin
                if (dec) begin
                  // Seventh 1 in a row: the transmitter failed to stuff.
                  stuff_err  <= 1'b1;
                  state      <= IDLE;
                  prev_level <= 1'b1;
                  armed      <= 1'b0;
                  ones_cnt   <= '0;
                end else begin
                  // Stuffed 0: consumed silently.
                  ones_cnt <= '0;
                end
              end else begin
                rx_bit       <= dec;
                rx_bit_valid <= 1'b1;
                ones_cnt     <= dec ? ones_cnt + 3'd1 : 3'd0;
              end
            end
          end

          EOP_WAIT: begin
            if (is_se0) begin
              if (se0_cnt == SE0_LIM) begin
                line_err   <= 1'b1;
                state      <= IDLE;
                prev_level <= 1'b1;
                armed      <= 1'b0;
                se0_cnt    <= '0;
                ones_cnt   <= '0;
              end else begin
                se0_cnt <= se0_cnt + SE0_W'(1);
              end
            end else begin
              // J closes the packet; K or SE1 after SE0 is a malformed EOP.
              if (is_j)
                eop <= 1'b1;
              else
                line_err <= 1'b1;
              state      <= IDLE;
              prev_level <= 1'b1;
              armed      <= 1'b0;
              se0_cnt    <= '0;
              ones_cnt   <= '0;
            end
          end

          default: begin
            state      <= IDLE;
            prev_level <= 1'b1;
            armed      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/usb_rx_nrzi_unstuff.md
Name: usb_rx_nrzi_unstuff

Overview:
Receive front end of the USB full-speed path.
- Samples the synchronized D+/D- pair once per bit-centre strobe.
- Performs NRZI decoding, SYNC detection, bit-unstuffing and EOP detection.
- Emits a clean decoded data bit with a one-cycle qualifying strobe. That strobe feeds directly into the CRC16 checker's bit-enable input and the downstream byte assembler, together with packet framing pulses.

Parameters:
SYNC_MIN_ZEROS, 3, minimum NRZI-decoded 0 bits before the terminating 1 for a valid SYNC (legal range 1..6; hubs may strip leading SYNC bits).
EOP_MAX_SE0, 3, maximum consecutive SE0 samples accepted as an EOP; one more is a line error.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sample_en  in  1  bit-centre strobe from clock recovery; dp/dm are evaluated only when high
dp  in  1  synchronized D+
dm  in  1  synchronized D-
rx_bit  out  1  decoded, unstuffed data bit; valid only with rx_bit_valid
rx_bit_valid  out  1  one-cycle pulse per delivered data bit
rx_active  out  1  high from sop cycle through eop/error cycle inclusive
sop  out  1  one-cycle pulse when SYNC completes
eop  out  1  one-cycle pulse on valid EOP
stuff_err  out  1  one-cycle pulse on bit-stuff violation
line_err  out  1  one-cycle pulse on SE1, bad EOP or over-long SE0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high, all outputs are 0, state is IDLE, prev_level is J, and all counters are 0.
- Line states: J = dp1/dm0, K = dp0/dm1, SE0 = 00, SE1 = 11.
- NRZI decode: decoded bit = 1 if the current J/K level equals prev_level, else 0. prev_level updates on every sample_en with J/K. prev_level is set to J when entering IDLE.
- Latency: all outputs are registered. Each is asserted in the cycle after the sample_en cycle that caused it. Pulses last exactly one cycle. No output changes on cycles without sample_en, except that pulses are deasserted.
- FSM states: IDLE, SYNC, DATA, EOP_WAIT.
- IDLE:
  - K while prev_level is J -> SYNC, zero_cnt=1.
  - Anything else -> stay.
- SYNC:
  - Decoded 0 -> zero_cnt++ (saturates at 7).
  - Decoded 1 with zero_cnt >= SYNC_MIN_ZEROS -> DATA, pulse sop, rx_active=1, ones_cnt=1.
  - Decoded 1 with zero_cnt below SYNC_MIN_ZEROS -> IDLE, no pulse.
  - SE0 or SE1 -> IDLE, no pulse.
- DATA:
  - If ones_cnt == 6: decoded 0 is a stuffed bit; drop it, ones_cnt=0, no rx_bit_valid.
  - If ones_cnt == 6 and decoded 1: pulse stuff_err, rx_active=0, go to IDLE.
  - Otherwise: rx_bit = decoded bit, pulse rx_bit_valid. ones_cnt = bit ? ones_cnt+1 : 0.
  - SE0 -> EOP_WAIT, se0_cnt=1, no bit delivered.
  - SE1 -> pulse line_err, rx_active=0, go to IDLE.
- EOP_WAIT:
  - SE0 -> se0_cnt++. If se0_cnt would exceed EOP_MAX_SE0, pulse line_err, rx_active=0, go to IDLE.
  - J -> pulse eop, rx_active=0, go to IDLE.
  - K or SE1 -> pulse line_err, rx_active=0, go to IDLE.
- Simultaneous events: at most one of sop/eop/stuff_err/line_err fires per sample. rx_bit_valid never coincides with eop or any error.
- IDLE re-arm: after any return to IDLE, a new SYNC requires at least one J sample before the K.
- Reset mid-packet: everything clears the next cycle, and no eop or error pulse is emitted.
- sample_en low for arbitrary gaps: state holds.

Test Plan:
- Clean packet: idle J x4, then SYNC KJKJKJKK, then data byte 0xA5 LSB-first NRZI-encoded, then SE0 SE0 J. Required: one sop, exactly 8 rx_bit_valid pulses carrying 1,0,1,0,0,1,0,1, then one eop. rx_active is high from sop through eop.
- Stuffing: payload 0xFF (eight 1s) after SYNC. The encoder inserts a 0 after the sixth 1 (the SYNC's last 1 counts toward the run). Required: 8 valid pulses, all 1, and no stuff_err.
- Stuff violation: after SYNC, send seven consecutive decoded 1s with no stuffed 0. Required: stuff_err pulses one cycle after the seventh 1, rx_active drops, and no eop follows.
- Short SYNC: SYNC with only 2 leading zeros (SYNC_MIN_ZEROS=3). Required: no sop and no rx_bit_valid. A following full SYNC is accepted.
- Bad EOP: data, then SE0 x4 then J. Required: line_err on the fourth SE0 and no eop. Separately, data, then SE0 then K gives line_err.
- Reset mid-packet with irregular sample_en: assert rst for one cycle after 3 data bits, with sample_en pulsing every 4 cycles. Required: all outputs 0 next cycle, and no pulses until a new J-then-SYNC.
